// File: rtl/frame_update_scheduler_if.sv
// Update handshake bundle between the frame scheduler (master) and its clients (slave).
// upd_req is one-hot while a sequence runs; each client answers on its own upd_ack bit.
interface frame_update_scheduler_if #(
   parameter int N_CLIENTS = 4
);
   logic [N_CLIENTS-1:0] upd_req;
   logic [N_CLIENTS-1:0] upd_ack;

   modport master (output upd_req, input upd_ack);
   modport slave  (input upd_req, output upd_ack);
endinterface

// File: rtl/frame_update_scheduler.sv
// Launches per-frame update sequences at vertical-blanking start and walks a one-hot request across the clients.
// Optional FRAME_SCHED_TIMEOUT_EN: an ack is assumed after TIMEOUT cycles of waiting and timeout_err is set.
module frame_update_scheduler #(
   parameter int N_CLIENTS = 4,
   parameter int V_ACTIVE  = 480,
   parameter int FRAME_DIV = 1,
   parameter int TIMEOUT   = 1023
) (
   input  logic                            clk,
   input  logic                            clr,
   input  logic [9:0]                      y,
   input  logic                            pause,
   frame_update_scheduler_if.master        upd,
   output logic                            busy,
   output logic [15:0]                     frame_cnt,
   output logic                            overrun,
   output logic                            timeout_err
);
   typedef enum logic {IDLE, REQ} state_t;

   state_t               state_reg, state_next;
   logic [N_CLIENTS-1:0] req_reg, req_next, ack_hit;
   logic [7:0]           div_reg, div_next;
   logic [15:0]          frame_reg, frame_next;
   logic                 in_vb, in_vb_q_reg, vb_start, act_start;
   logic                 overrun_reg, advance, timeout_hit;

   assign in_vb     = (y >= 10'(V_ACTIVE));
   assign vb_start  = in_vb & ~in_vb_q_reg;
   assign act_start = ~in_vb & in_vb_q_reg;

   // Only the ack of the currently requested client counts.
   genvar gi;
   for (gi = 0; gi < N_CLIENTS; gi++) begin : g_hit
      assign ack_hit[gi] = req_reg[gi] & upd.upd_ack[gi];
   end

   assign advance = (state_reg == REQ) && ((|ack_hit) || timeout_hit);

   always_comb begin
      state_next = state_reg;
      req_next   = req_reg;
      div_next   = div_reg;
      frame_next = frame_reg;
      case (state_reg)
         IDLE: begin
            if (vb_start && !pause) begin
               if (div_reg == 8'(FRAME_DIV - 1)) begin
                  div_next   = '0;
                  state_next = REQ;
                  req_next   = N_CLIENTS'(1);
                  frame_next = frame_reg + 16'd1;
               end else begin
                  div_next = div_reg + 8'd1;
               end
            end
         end
         REQ: begin
            if (advance) begin
               if (req_reg[N_CLIENTS-1]) begin
                  state_next = IDLE;
                  req_next   = '0;
               end else begin
                  req_next = req_reg << 1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            req_next   = '0;
         end
      endcase
   end

   // in_vb_q resets high so leaving reset inside blanking is not a blanking start.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_reg   <= IDLE;
         req_reg     <= '0;
         div_reg     <= '0;
         frame_reg   <= '0;
         in_vb_q_reg <= 1'b1;
         overrun_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         req_reg     <= req_next;
         div_reg     <= div_next;
         frame_reg   <= frame_next;
         in_vb_q_reg <= in_vb;
         if (act_start && (state_reg == REQ)) begin
            overrun_reg <= 1'b1;
         end
      end
   end

`ifdef FRAME_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] wait_reg;
   logic          terr_reg;

   assign timeout_hit = (state_reg == REQ) && (wait_reg == TW'(TIMEOUT - 1)) && !(|ack_hit);

   // Counter restarts whenever a new client is requested.
   always_ff @(posedge clk) begin
      if (clr) begin
         wait_reg <= '0;
         terr_reg <= 1'b0;
      end else begin
         if ((state_reg != REQ) || advance) begin
            wait_reg <= '0;
         end else begin
            wait_reg <= wait_reg + 1'b1;
         end
         if (timeout_hit) begin
            terr_reg <= 1'b1;
         end
      end
   end

   assign timeout_err = terr_reg;
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign upd.upd_req = req_reg;
   assign busy        = (state_reg == REQ);
   assign frame_cnt   = frame_reg;
   assign overrun     = overrun_reg;
endmodule

// File: tb/tb_frame_update_scheduler.sv
// Bench for frame_update_scheduler: a table-driven basic sequence, hand-written corner cases,
// and a randomized run, all checked against a client-index reference model.
module tb_frame_update_scheduler;
   localparam int TO = 10;
`ifdef FRAME_SCHED_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        clr;
   logic [9:0]  y;
   logic        pause;
   logic [3:0]  ack_a, ack_b;
   logic        busy_a, busy_b, ovr_a, ovr_b, terr_a, terr_b;
   logic [15:0] fc_a, fc_b;

   always #5 clk = ~clk;

   frame_update_scheduler_if #(.N_CLIENTS(4)) bus_a ();
   frame_update_scheduler_if #(.N_CLIENTS(4)) bus_b ();
   assign bus_a.upd_ack = ack_a;
   assign bus_b.upd_ack = ack_b;

   frame_update_scheduler #(.N_CLIENTS(4), .V_ACTIVE(480), .FRAME_DIV(1), .TIMEOUT(TO)) dut_a (
      .clk(clk), .clr(clr), .y(y), .pause(pause), .upd(bus_a),
      .busy(busy_a), .frame_cnt(fc_a), .overrun(ovr_a), .timeout_err(terr_a));

   frame_update_scheduler #(.N_CLIENTS(4), .V_ACTIVE(480), .FRAME_DIV(3), .TIMEOUT(TO)) dut_b (
      .clk(clk), .clr(clr), .y(y), .pause(pause), .upd(bus_b),
      .busy(busy_b), .frame_cnt(fc_b), .overrun(ovr_b), .timeout_err(terr_b));

   int total = 0;
   int bad   = 0;

   // Reference model: which client is being served (-1 = none), eligible-start count, etc.
   typedef struct {
      int cur;
      int div;
      int fcnt;
      bit prev_vb;
      bit ovr;
      bit terr;
      int waitc;
   } mdl_t;

   mdl_t ma, mb;

   typedef struct {
      int         yy;
      logic [3:0] ack;
      logic [3:0] req;
      bit         bsy;
      int         fc;
   } vec_t;

   vec_t tbl[16];

   function automatic mdl_t mstep(mdl_t m, bit rst, int yy, bit pz, logic [3:0] ack, int fdiv);
      mdl_t n = m;
      bit vb = (yy >= 480);
      bit done;
      if (rst) begin
         n.cur = -1; n.div = 0; n.fcnt = 0; n.prev_vb = 1'b1;
         n.ovr = 1'b0; n.terr = 1'b0; n.waitc = 0;
         return n;
      end
      if (!vb && m.prev_vb && m.cur >= 0) n.ovr = 1'b1;
      if (m.cur < 0) begin
         if (vb && !m.prev_vb && !pz) begin
            n.div = m.div + 1;
            if (n.div == fdiv) begin
               n.div = 0; n.cur = 0; n.waitc = 0;
               n.fcnt = (m.fcnt + 1) % 65536;
            end
         end
      end else begin
         done = ack[m.cur];
         if (!done) begin
            n.waitc = m.waitc + 1;
            if (TO_EN && n.waitc == TO) begin
               done = 1'b1;
               n.terr = 1'b1;
            end
         end
         if (done) begin
            n.waitc = 0;
            n.cur = (m.cur == 3) ? -1 : m.cur + 1;
         end
      end
      n.prev_vb = vb;
      return n;
   endfunction

   function automatic int ereq(mdl_t m);
      logic [3:0] one = 4'd1;
      if (m.cur < 0) return 0;
      return int'(one << m.cur);
   endfunction

   task automatic chk(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      int prev_fc;
      prev_fc = ma.fcnt;
      @(posedge clk);
      ma = mstep(ma, clr, int'(y), pause, ack_a, 1);
      mb = mstep(mb, clr, int'(y), pause, ack_b, 3);
      @(negedge clk);
      chk("a_req",  int'(bus_a.upd_req), ereq(ma));
      chk("a_busy", int'(busy_a), int'(ma.cur >= 0));
      chk("a_fcnt", int'(fc_a), ma.fcnt);
      chk("a_ovr",  int'(ovr_a), int'(ma.ovr));
      chk("a_terr", int'(terr_a), int'(ma.terr));
      chk("b_req",  int'(bus_b.upd_req), ereq(mb));
      chk("b_busy", int'(busy_b), int'(mb.cur >= 0));
      chk("b_fcnt", int'(fc_b), mb.fcnt);
      chk("b_ovr",  int'(ovr_b), int'(mb.ovr));
      chk("b_terr", int'(terr_b), int'(mb.terr));
      if (ma.fcnt != prev_fc) $display("launch a: frame=%0d t=%0t", ma.fcnt, $time);
   endtask

   task automatic do_reset();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic vb_pulse(int nblank);
      y = 10'd479;
      tick();
      for (int k = 0; k < nblank; k++) begin
         y = 10'(480 + k);
         tick();
      end
   endtask

   initial begin
      // Basic sequence: launch on 479->480, each client acks on the third cycle of its req.
      tbl[0]  = '{478, 4'b0000, 4'b0000, 1'b0, 0};
      tbl[1]  = '{479, 4'b0000, 4'b0000, 1'b0, 0};
      tbl[2]  = '{480, 4'b0000, 4'b0001, 1'b1, 1};
      tbl[3]  = '{481, 4'b0000, 4'b0001, 1'b1, 1};
      tbl[4]  = '{482, 4'b0000, 4'b0001, 1'b1, 1};
      tbl[5]  = '{483, 4'b0001, 4'b0010, 1'b1, 1};
      tbl[6]  = '{484, 4'b0000, 4'b0010, 1'b1, 1};
      tbl[7]  = '{485, 4'b0000, 4'b0010, 1'b1, 1};
      tbl[8]  = '{486, 4'b0010, 4'b0100, 1'b1, 1};
      tbl[9]  = '{487, 4'b0000, 4'b0100, 1'b1, 1};
      tbl[10] = '{488, 4'b0000, 4'b0100, 1'b1, 1};
      tbl[11] = '{489, 4'b0100, 4'b1000, 1'b1, 1};
      tbl[12] = '{490, 4'b0000, 4'b1000, 1'b1, 1};
      tbl[13] = '{491, 4'b0000, 4'b1000, 1'b1, 1};
      tbl[14] = '{492, 4'b1000, 4'b0000, 1'b0, 1};
      tbl[15] = '{493, 4'b0000, 4'b0000, 1'b0, 1};

      clr = 1'b1; y = 10'd470; pause = 1'b0; ack_a = 4'h0; ack_b = 4'hF;
      tick();
      tick();
      chk("rst_req", int'(bus_a.upd_req), 0);
      chk("rst_fc", int'(fc_a), 0);
      clr = 1'b0;
      for (int r = 470; r < 478; r++) begin
         y = 10'(r);
         tick();
      end
      for (int i = 0; i < 16; i++) begin
         y = 10'(tbl[i].yy);
         ack_a = tbl[i].ack;
         tick();
         chk("tbl_req",  int'(bus_a.upd_req), int'(tbl[i].req));
         chk("tbl_busy", int'(busy_a), int'(tbl[i].bsy));
         chk("tbl_fc",   int'(fc_a), tbl[i].fc);
         $display("vec %0d: y=%0d ack=%b req=%b busy=%b fc=%0d", i, tbl[i].yy, tbl[i].ack, bus_a.upd_req, busy_a, fc_a);
      end

      // Divider: FRAME_DIV=3 launches on the 3rd and 6th blanking starts only.
      do_reset();
      ack_a = 4'hF; ack_b = 4'hF;
      for (int s = 1; s <= 7; s++) begin
         vb_pulse(8);
         chk("div_fc_b", int'(fc_b), s / 3);
         $display("blank start %0d: fc_a=%0d fc_b=%0d", s, fc_a, fc_b);
      end
      chk("div_fc_a", int'(fc_a), 7);

      // Pause suppresses the launch only at the blanking start where it is high.
      do_reset();
      pause = 1'b1;
      vb_pulse(8);
      chk("pause_fc", int'(fc_a), 0);
      pause = 1'b0;
      vb_pulse(8);
      chk("unpause_fc", int'(fc_a), 1);
      chk("unpause_busy", int'(busy_a), 0);
      $display("pause: fc_a=%0d", fc_a);

      // Overrun: client 2 withholds ack while y wraps 1023 -> 0.
      do_reset();
      ack_a = 4'b0011;
      y = 10'd479;  tick();
      y = 10'd480;  tick();
      chk("ovr_launch", int'(bus_a.upd_req), 1);
      y = 10'd481;  tick();
      y = 10'd1023; tick();
      chk("ovr_pre_req", int'(bus_a.upd_req), 4);
      chk("ovr_pre", int'(ovr_a), 0);
      y = 10'd0;    tick();
      chk("ovr_set", int'(ovr_a), 1);
      chk("ovr_req", int'(bus_a.upd_req), 4);
      for (int k = 1; k < 4; k++) begin
         y = 10'(k);
         tick();
      end
      chk("ovr_sticky", int'(ovr_a), 1);
      clr = 1'b1;
      tick();
      chk("clr_req", int'(bus_a.upd_req), 0);
      chk("clr_busy", int'(busy_a), 0);
      chk("clr_ovr", int'(ovr_a), 0);
      clr = 1'b0;
      $display("overrun/reset sequence complete");

      // Timeout: client 1 never acks.
      do_reset();
      ack_a = 4'b0001;
      y = 10'd479; tick();
      y = 10'd480; tick();
      y = 10'd481; tick();
      chk("to_enter", int'(bus_a.upd_req), 2);
      y = 10'd500;
      for (int k = 1; k < TO; k++) begin
         tick();
         chk("to_hold", int'(bus_a.upd_req), 2);
      end
      tick();
      chk("to_move", int'(bus_a.upd_req), TO_EN ? 4 : 2);
      chk("to_err", int'(terr_a), int'(TO_EN));
      for (int k = 0; k < 25; k++) tick();
      $display("timeout: req=%b terr=%b", bus_a.upd_req, terr_a);

      // Leaving reset inside blanking must not launch.
      y = 10'd500; ack_a = 4'hF;
      do_reset();
      for (int k = 0; k < 4; k++) tick();
      chk("rstvb_fc", int'(fc_a), 0);
      chk("rstvb_req", int'(bus_a.upd_req), 0);
      y = 10'd479; tick();
      y = 10'd480; tick();
      chk("rstvb_launch_fc", int'(fc_a), 1);
      chk("rstvb_launch_req", int'(bus_a.upd_req), 1);
      for (int k = 1; k < 6; k++) begin
         y = 10'(480 + k);
         tick();
      end

      // Randomized run against the model.
      do_reset();
      for (int it = 0; it < 2000; it++) begin
         int r;
         r = it % 30;
         if (r < 10)      y = 10'(470 + r);
         else if (r < 22) y = 10'(480 + r - 10);
         else             y = 10'(1012 + r - 22);
         if ($urandom_range(0, 15) == 0) y = 10'($urandom_range(0, 1023));
         pause = ($urandom_range(0, 3) == 0);
         ack_a = 4'($urandom);
         ack_b = 4'($urandom);
         clr   = ($urandom_range(0, 199) == 0);
         tick();
      end
      clr = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
